// File: rtl/jstepper_pkg.sv
// Shared definitions for the instruction-step sequencer: phase encoding,
// default step count and the gate-library primitives used for all decode.
package jstepper_pkg;

    localparam int NSTEPS_DEFAULT = 6;

    typedef enum logic [1:0] {
        PH_E0  = 2'd0,
        PH_S   = 2'd1,
        PH_E2  = 2'd2,
        PH_GAP = 2'd3
    } phase_t;

    function automatic logic jand(input logic a, input logic b);
        return a & b;
    endfunction

    function automatic logic jor(input logic a, input logic b);
        return a | b;
    endfunction

    function automatic logic jnot(input logic a);
        return ~a;
    endfunction

endpackage

// File: rtl/jstepper_ring.sv
// One-hot rotating step register; load1 returns the ring to step 1 and
// takes priority over a rotate request.
module jstep_ring
    import jstepper_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              load1,
    output logic [NSTEPS-1:0] q
);

    localparam logic [NSTEPS-1:0] STEP1 = NSTEPS'(1);

    always_ff @(posedge clk) begin
        if (reset || load1) begin
            q <= STEP1;
        end else if (adv) begin
            q <= {q[NSTEPS-2:0], q[NSTEPS-1]};
        end
    end

endmodule

// File: rtl/jstepper.sv
// Instruction-step sequencer: four base-clock phases per step, enable/set
// strobes, one-hot step bus, hold at step boundaries and latched restart.
module jstepper
    import jstepper_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              restart,
    output logic              clke,
    output logic              clks,
    output logic [NSTEPS-1:0] step,
    output logic [1:0]        phase,
    output logic              last
);

    phase_t phase_q, phase_d;
    logic   pending_q, pending_d;
    logic   started_q, started_d;
    logic   boundary;
    logic   restart_now;
    logic   go;
    logic   ring_load1;
    logic   ring_adv;

    assign boundary    = jand(phase_q[1], phase_q[0]);
    assign restart_now = jand(boundary, jor(restart, pending_q));
    assign go          = jand(boundary, jand(jnot(restart_now), jnot(hold)));

    // The ring already sits on step 1 after reset, so the first boundary
    // out of reset loads step 1 instead of rotating past it.
    assign ring_load1  = jor(restart_now, jand(go, jnot(started_q)));
    assign ring_adv    = jand(go, started_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PH_GAP;
            pending_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pending_q <= pending_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        pending_d = pending_q;
        started_d = started_q;
        if (!boundary) begin
            phase_d = phase_t'(phase_q + 2'd1);
            if (restart) begin
                pending_d = 1'b1;
            end
        end else if (restart_now) begin
            phase_d   = PH_E0;
            pending_d = 1'b0;
            started_d = 1'b1;
        end else if (!hold) begin
            phase_d   = PH_E0;
            started_d = 1'b1;
        end
    end

    jstep_ring #(
        .NSTEPS (NSTEPS)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .adv   (ring_adv),
        .load1 (ring_load1),
        .q     (step)
    );

    assign clke  = jnot(boundary);
    assign clks  = jand(jnot(phase_q[1]), phase_q[0]);
    assign phase = phase_q;
    assign last  = step[NSTEPS-1];

endmodule

// File: tb/tb_jstepper.sv
// Bench for jstepper: three instances (6, 2 and 8 steps) checked every cycle
// against a step-index/phase model, plus directed literal expectations.
module tb_jstepper;

    logic clk = 1'b0;
    logic reset, hold, restart;

    logic       clke6, clks6, last6;
    logic [5:0] step6;
    logic [1:0] phase6;
    logic       clke2, clks2, last2;
    logic [1:0] step2;
    logic [1:0] phase2;
    logic       clke8, clks8, last8;
    logic [7:0] step8;
    logic [1:0] phase8;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    jstepper #(.NSTEPS(6)) u6 (
        .clk(clk), .reset(reset), .hold(hold), .restart(restart),
        .clke(clke6), .clks(clks6), .step(step6), .phase(phase6), .last(last6)
    );
    jstepper #(.NSTEPS(2)) u2 (
        .clk(clk), .reset(reset), .hold(hold), .restart(restart),
        .clke(clke2), .clks(clks2), .step(step2), .phase(phase2), .last(last2)
    );
    jstepper #(.NSTEPS(8)) u8 (
        .clk(clk), .reset(reset), .hold(hold), .restart(restart),
        .clke(clke8), .clks(clks8), .step(step8), .phase(phase8), .last(last8)
    );

    logic [7:0] a_step  [3];
    logic [1:0] a_phase [3];
    logic       a_clke  [3];
    logic       a_clks  [3];
    logic       a_last  [3];

    assign a_step[0] = 8'(step6);  assign a_phase[0] = phase6;
    assign a_clke[0] = clke6;      assign a_clks[0]  = clks6;  assign a_last[0] = last6;
    assign a_step[1] = 8'(step2);  assign a_phase[1] = phase2;
    assign a_clke[1] = clke2;      assign a_clks[1]  = clks2;  assign a_last[1] = last2;
    assign a_step[2] = step8;      assign a_phase[2] = phase8;
    assign a_clke[2] = clke8;      assign a_clks[2]  = clks8;  assign a_last[2] = last8;

    // Model: which step (0-based index) and which phase each instance is in.
    int   nsteps    [3] = '{6, 2, 8};
    int   m_idx     [3];
    int   m_ph      [3];
    bit   m_pend    [3];
    bit   m_started [3];
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  idx, ph;
            bit  pend, started;
            idx = m_idx[i]; ph = m_ph[i]; pend = m_pend[i]; started = m_started[i];
            if (reset) begin
                idx = 0; ph = 3; pend = 0; started = 0;
            end else if (ph != 3) begin
                ph = ph + 1;
                if (restart) pend = 1;
            end else if (restart || pend) begin
                idx = 0; ph = 0; pend = 0; started = 1;
            end else if (!hold) begin
                idx = started ? (idx + 1) % nsteps[i] : 0;
                ph = 0; started = 1;
            end
            m_idx[i] <= idx; m_ph[i] <= ph; m_pend[i] <= pend; m_started[i] <= started;
        end
        if (reset) m_valid <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                logic [7:0] exp_step;
                exp_step = 8'(1) << m_idx[i];
                checkOutput($sformatf("model.step[%0d]", i), 32'(a_step[i]), 32'(exp_step));
                checkOutput($sformatf("model.phase[%0d]", i), 32'(a_phase[i]), 32'(m_ph[i]));
                checkOutput($sformatf("model.clke[%0d]", i), 32'(a_clke[i]), 32'(m_ph[i] != 3));
                checkOutput($sformatf("model.clks[%0d]", i), 32'(a_clks[i]), 32'(m_ph[i] == 1));
                checkOutput($sformatf("model.last[%0d]", i), 32'(a_last[i]),
                            32'(m_idx[i] == nsteps[i] - 1));
                checkOutput($sformatf("onehot[%0d]", i), 32'($onehot(a_step[i])), 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic rs, input int n);
        reset = r; hold = h; restart = rs;
        tick(n);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; restart = 1'b0;
        tick(1);
        checkOutput("reset.phase", 32'(phase6), 32'd3);
        checkOutput("reset.clke", 32'(clke6), 32'd0);
        checkOutput("reset.clks", 32'(clks6), 32'd0);
        checkOutput("reset.step", 32'(step6), 32'b000001);
        checkOutput("reset.last", 32'(last6), 32'd0);

        // Free run; t counts cycles after the reset-state cycle.
        reset = 1'b0;
        for (int t = 1; t <= 33; t++) begin
            tick(1);
            case (t)
                1: begin
                    checkOutput("run.t1.step", 32'(step6), 32'b000001);
                    checkOutput("run.t1.phase", 32'(phase6), 32'd0);
                    checkOutput("run.t1.clke", 32'(clke6), 32'd1);
                    checkOutput("run.t1.clks", 32'(clks6), 32'd0);
                end
                2: checkOutput("run.t2.clks", 32'(clks6), 32'd1);
                4: begin
                    checkOutput("run.t4.phase", 32'(phase6), 32'd3);
                    checkOutput("run.t4.clke", 32'(clke6), 32'd0);
                end
                5: begin
                    checkOutput("run.t5.step", 32'(step6), 32'b000010);
                    checkOutput("run.n2.t5.step", 32'(step2), 32'b10);
                end
                9:  checkOutput("run.n2.wrap", 32'(step2), 32'b01);
                21: begin
                    checkOutput("run.t21.step", 32'(step6), 32'b100000);
                    checkOutput("run.t21.last", 32'(last6), 32'd1);
                end
                25: begin
                    checkOutput("run.wrap.step", 32'(step6), 32'b000001);
                    checkOutput("run.wrap.last", 32'(last6), 32'd0);
                end
                29: checkOutput("run.n8.last", 32'(step8), 32'h80);
                33: checkOutput("run.n8.wrap", 32'(step8), 32'h01);
                default: ;
            endcase
        end

        // Hold requested in step 3 phase 1, kept for five cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        checkOutput("hold.phase", 32'(phase6), 32'd3);
        checkOutput("hold.clke", 32'(clke6), 32'd0);
        checkOutput("hold.step", 32'(step6), 32'b000100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("release.step", 32'(step6), 32'b001000);
        checkOutput("release.phase", 32'(phase6), 32'd0);

        // Restart pulse at step 4 phase 0: step 4 completes, then step 1.
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("restart.ph3.step", 32'(step6), 32'b001000);
        checkOutput("restart.ph3.phase", 32'(phase6), 32'd3);
        tick(1);
        checkOutput("restart.step", 32'(step6), 32'b000001);
        checkOutput("restart.phase", 32'(phase6), 32'd0);

        // Restart and hold together on the step-5 boundary.
        tick(19);
        checkOutput("rh.pre.step", 32'(step6), 32'b010000);
        checkOutput("rh.pre.phase", 32'(phase6), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("rh.step", 32'(step6), 32'b000001);
        checkOutput("rh.phase", 32'(phase6), 32'd0);

        // Reset in step 5 phase 2 with a restart pending; hold right after
        // reset exposes any restart that survived the reset.
        applyStimulus(1'b0, 1'b0, 1'b0, 16);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("rst.pre.phase", 32'(phase6), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rst.phase", 32'(phase6), 32'd3);
        checkOutput("rst.step", 32'(step6), 32'b000001);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("rst.hold.phase", 32'(phase6), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("rst.start.phase", 32'(phase6), 32'd0);
        tick(4);
        checkOutput("rst.next.step", 32'(step6), 32'b000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
